core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
Run-control and clock-enable generator for the pipelined core, sitting beside the pipeline at the top level. It produces NUM_CH independent divided clock-enable pulse trains, runs the RUN/SLEEP/HALT state machine driven by writeback halt/sleep requests, and handles masked interrupt wake and debug resume. It also keeps the run-cycle counter that is exported as the return/cycle value.

Parameters:
NUM_CH, 2, number of clock-enable channels; channel 0 gates the core pipeline.
DIV_W, 32, width of each channel divider value.
NUM_IRQ, 16, number of interrupt request lines.
CNT_W, 32, cycle counter width.
CNT_SAT, 0, cycle counter overflow mode: 1 saturates at all-ones, 0 wraps to 0.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
divider  in  NUM_CH*DIV_W  per-channel divide value; channel c occupies bits [c*DIV_W +: DIV_W]
irq  in  NUM_IRQ  level interrupt requests
irq_mask  in  NUM_IRQ  1 = line enabled for wake
wb_halt  in  1  halt request from writeback
wb_sleep  in  1  sleep request from writeback
resume  in  1  debug resume pulse; leaves HALT
clk_en  out  NUM_CH  per-channel one-cycle enable pulses
core_en  out  1  clk_en[0] AND state==RUN
state  out  2  00 RUN, 01 SLEEP, 10 HALT
wake_pending  out  1  sticky masked-interrupt seen while in SLEEP
cycle_count  out  CNT_W  run-cycle counter

Behaviour:
- Reset (rst_n low, asynchronous): cnt[c]=0, clk_en=0, state=RUN, wake_pending=0, cycle_count=0, core_en=0.
- Divider per channel:
  - Each clk edge: if cnt[c] >= divider[c], then cnt[c]<=0 and clk_en[c]<=1; otherwise cnt[c]<=cnt[c]+1 and clk_en[c]<=0.
  - Resulting period is divider+1 cycles. divider=0 gives clk_en high every cycle from the first edge after reset release.
  - divider is compared live. If it is lowered below the current cnt, the next edge fires a pulse and restarts the count.
  - Channels are fully independent. The counter never wraps, because the >= compare resets it first.
- FSM (RUN/SLEEP/HALT). Transitions commit only on edges where clk_en[0]==1, except the wake_pending capture.
  - RUN: wb_halt goes to HALT. Otherwise wb_sleep goes to SLEEP. wb_halt has priority when both are high.
  - SLEEP: goes to RUN when (irq&irq_mask)!=0 or wake_pending==1. wb_halt and wb_sleep are ignored.
  - HALT: sticky. Goes to RUN only when resume==1. wb_* are ignored.
  - resume is ignored outside HALT. resume is also sampled only on clk_en[0] edges, so the pulse must span one.
  - Unused encoding 11 recovers to RUN on the next clk_en[0] edge.
- wake_pending:
  - In SLEEP, it sets on any edge (regardless of clk_en) where (irq&irq_mask)!=0. This guarantees a short irq between enable pulses is not lost.
  - It clears on the edge that commits SLEEP to RUN.
  - It is held at 0 outside SLEEP.
- Interrupt wake uses the full NUM_IRQ width. Masked-off lines never wake the core.
- core_en is combinational: clk_en[0] & (state==RUN).
- cycle_count:
  - Increments by 1 on every clk edge while state!=HALT, including SLEEP, independent of clk_en.
  - Frozen in HALT.
  - At all-ones it wraps to 0 when CNT_SAT=0 and holds when CNT_SAT=1.
- Reset asserted mid-operation: everything returns immediately to reset values. Any pending halt, sleep or wake is discarded.

Decomposition:
- Shared package core_pkg holds:
  - the state encoding constants RUN_ST=2'b00, SLEEP_ST=2'b01, HALT_ST=2'b10;
  - the default DIV_W, NUM_IRQ and CNT_W constants.
- One sub-module, clk_en_div (a single divider channel with parameter DIV_W), is instantiated NUM_CH times through a generate loop.
- The FSM, wake latch and cycle counter stay in core_run_ctrl.

Test Plan:
- Divider sweep, divider ch0=0 and ch1=3: clk_en[0] is high every cycle after reset release; clk_en[1] pulses every 4th cycle (edges 4, 8, 12).
- Live divider drop, ch1 divider=9: after cnt reaches 6, write 2. clk_en[1] pulses on the next edge, then every 3 cycles.
- Halt priority, with divider ch0=1 and wb_halt=wb_sleep=1 on a clk_en[0] edge: state goes to 10 and core_en drops to 0. cycle_count freezes at its value, e.g. stays 37 for 20 cycles. A resume spanning a clk_en[0] edge returns state to 00 and counting resumes.
- Sleep with masked wake, irq_mask=16'h0004, in SLEEP:
  - irq=16'h0001 keeps the core in SLEEP.
  - A 1-cycle irq=16'h0004 pulse between enable pulses sets wake_pending=1.
  - At the next clk_en[0] edge, state becomes RUN and wake_pending becomes 0.
- Counter overflow, CNT_W=4: with CNT_SAT=0, cycle_count runs 15 then 0. With CNT_SAT=1, it runs 15 then 15.
- Async reset while in SLEEP with wake_pending=1: drop rst_n mid-cycle. All outputs clear immediately with no clk edge, and state is 00 after release.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core run-control slice.
//   - core_state_e : run-control state encoding (RUN/SLEEP/HALT, 2'b11 unused)
//   - DEF_*        : default widths used by core_run_ctrl and clk_en_div
package core_pkg;

    typedef enum logic [1:0] {
        RUN_ST   = 2'b00,
        SLEEP_ST = 2'b01,
        HALT_ST  = 2'b10
    } core_state_e;

    localparam int DEF_DIV_W   = 32;
    localparam int DEF_NUM_IRQ = 16;
    localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: one clock-enable divider channel.
// Emits a one-cycle clk_en pulse every divider+1 cycles.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   divider - divide value, compared live every cycle
//   clk_en  - registered enable pulse
module clk_en_div
    import core_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divider,
    output logic             clk_en
);

    logic [DIV_W-1:0] cnt_reg;
    logic             clk_en_reg;

    // The >= compare (rather than ==) means lowering divider below the
    // running count fires on the next edge instead of waiting for a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            clk_en_reg <= 1'b0;
        end else if (cnt_reg >= divider) begin
            cnt_reg    <= '0;
            clk_en_reg <= 1'b1;
        end else begin
            cnt_reg    <= cnt_reg + 1'b1;
            clk_en_reg <= 1'b0;
        end
    end

    assign clk_en = clk_en_reg;

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run control and clock-enable generation for the core.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   divider           - per-channel divide values, channel c at [c*DIV_W +: DIV_W]
//   irq, irq_mask     - level interrupts and per-line wake enables
//   wb_halt, wb_sleep - halt / sleep requests from writeback
//   resume            - debug resume, only meaningful in HALT
//   clk_en            - per-channel enable pulses (channel 0 gates the pipeline)
//   core_en           - clk_en[0] while in RUN
//   state             - 00 RUN, 01 SLEEP, 10 HALT
//   wake_pending      - masked interrupt seen while sleeping, not yet serviced
//   cycle_count       - cycles spent outside HALT
module core_run_ctrl
    import core_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int NUM_IRQ = DEF_NUM_IRQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int CNT_SAT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*DIV_W-1:0] divider,
    input  logic [NUM_IRQ-1:0]      irq,
    input  logic [NUM_IRQ-1:0]      irq_mask,
    input  logic                    wb_halt,
    input  logic                    wb_sleep,
    input  logic                    resume,
    output logic [NUM_CH-1:0]       clk_en,
    output logic                    core_en,
    output logic [1:0]              state,
    output logic                    wake_pending,
    output logic [CNT_W-1:0]        cycle_count
);

    core_state_e      state_reg, state_next;
    logic             wake_pending_reg, wake_pending_next;
    logic [CNT_W-1:0] cycle_count_reg;
    logic             irq_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_div
            clk_en_div #(
                .DIV_W(DIV_W)
            ) u_div (
                .clk    (clk),
                .rst_n  (rst_n),
                .divider(divider[gi*DIV_W +: DIV_W]),
                .clk_en (clk_en[gi])
            );
        end
    endgenerate

    assign irq_hit = |(irq & irq_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= RUN_ST;
            wake_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wake_pending_reg <= wake_pending_next;
        end
    end

    // State moves only on channel-0 enable edges, but the wake latch in
    // SLEEP captures on every edge so an irq shorter than the enable
    // period still wakes the core at the next enable.
    always_comb begin
        state_next        = state_reg;
        wake_pending_next = 1'b0;
        case (state_reg)
            RUN_ST: begin
                if (clk_en[0]) begin
                    if (wb_halt) begin
                        state_next = HALT_ST;
                    end else if (wb_sleep) begin
                        state_next = SLEEP_ST;
                    end
                end
            end
            SLEEP_ST: begin
                wake_pending_next = wake_pending_reg | irq_hit;
                if (clk_en[0] && (irq_hit || wake_pending_reg)) begin
                    state_next        = RUN_ST;
                    wake_pending_next = 1'b0;
                end
            end
            HALT_ST: begin
                if (clk_en[0] && resume) begin
                    state_next = RUN_ST;
                end
            end
            default: begin
                if (clk_en[0]) begin
                    state_next = RUN_ST;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_reg <= '0;
        end else if (state_reg != HALT_ST) begin
            if (cycle_count_reg == {CNT_W{1'b1}}) begin
                if (CNT_SAT == 0) begin
                    cycle_count_reg <= '0;
                end
            end else begin
                cycle_count_reg <= cycle_count_reg + 1'b1;
            end
        end
    end

    assign state        = state_reg;
    assign wake_pending = wake_pending_reg;
    assign cycle_count  = cycle_count_reg;
    assign core_en      = clk_en[0] & (state_reg == RUN_ST);

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] divider;
    logic [15:0] irq;
    logic [15:0] irq_mask;
    logic        wb_halt;
    logic        wb_sleep;
    logic        resume;

    logic [1:0]  clk_en;
    logic        core_en;
    logic [1:0]  state;
    logic        wake_pending;
    logic [31:0] cycle_count;

    // Narrow-counter instances for the overflow check (wrap and saturate).
    logic [1:0]  w_clk_en, s_clk_en;
    logic        w_core_en, s_core_en;
    logic [1:0]  w_state, s_state;
    logic        w_wake, s_wake;
    logic [3:0]  w_count, s_count;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    core_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .divider(divider), .irq(irq), .irq_mask(irq_mask),
        .wb_halt(wb_halt), .wb_sleep(wb_sleep), .resume(resume),
        .clk_en(clk_en), .core_en(core_en), .state(state),
        .wake_pending(wake_pending), .cycle_count(cycle_count)
    );

    core_run_ctrl #(.CNT_W(4), .CNT_SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .divider(divider), .irq(irq), .irq_mask(irq_mask),
        .wb_halt(wb_halt), .wb_sleep(wb_sleep), .resume(resume),
        .clk_en(w_clk_en), .core_en(w_core_en), .state(w_state),
        .wake_pending(w_wake), .cycle_count(w_count)
    );

    core_run_ctrl #(.CNT_W(4), .CNT_SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .divider(divider), .irq(irq), .irq_mask(irq_mask),
        .wb_halt(wb_halt), .wb_sleep(wb_sleep), .resume(resume),
        .clk_en(s_clk_en), .core_en(s_core_en), .state(s_state),
        .wake_pending(s_wake), .cycle_count(s_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release 1 time unit after an edge; edge 1
    // is the next posedge.
    task automatic do_reset(input logic [31:0] d0, input logic [31:0] d1);
        rst_n    = 1'b0;
        divider  = {d1, d0};
        irq      = '0;
        irq_mask = '0;
        wb_halt  = 1'b0;
        wb_sleep = 1'b0;
        resume   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(32'd0, 32'd3);
        rst_n = 1'b0;
        tick();
        vec_count++;
        if (clk_en !== 2'b00) begin err_count++; $display("FAIL reset_clk_en: got %b want 00", clk_en); end
        vec_count++;
        if (state !== 2'b00) begin err_count++; $display("FAIL reset_state: got %b want 00", state); end
        vec_count++;
        if (wake_pending !== 1'b0) begin err_count++; $display("FAIL reset_wake: got %b want 0", wake_pending); end
        vec_count++;
        if (cycle_count !== 32'd0) begin err_count++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        vec_count++;
        if (core_en !== 1'b0) begin err_count++; $display("FAIL reset_core_en: got %b want 0", core_en); end
        $display("test_reset done");
    endtask

    task automatic test_divider();
        do_reset(32'd0, 32'd3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            vec_count++;
            if (clk_en[0] !== 1'b1) begin err_count++; $display("FAIL div_ch0 edge %0d: got %b want 1", k, clk_en[0]); end
            vec_count++;
            if (clk_en[1] !== ((k % 4) == 0)) begin err_count++; $display("FAIL div_ch1 edge %0d: got %b want %b", k, clk_en[1], (k % 4) == 0); end
            vec_count++;
            if (core_en !== 1'b1) begin err_count++; $display("FAIL div_core_en edge %0d: got %b want 1", k, core_en); end
            vec_count++;
            if (cycle_count !== 32'(k)) begin err_count++; $display("FAIL div_count edge %0d: got %0d want %0d", k, cycle_count, k); end
        end
        $display("test_divider done");
    endtask

    task automatic test_live_drop();
        logic exp_en;
        do_reset(32'd0, 32'd9);
        for (int k = 1; k <= 14; k++) begin
            if (k == 7) divider[63:32] = 32'd2;
            tick();
            exp_en = (k == 7) || (k == 10) || (k == 13);
            vec_count++;
            if (clk_en[1] !== exp_en) begin err_count++; $display("FAIL live_drop edge %0d: got %b want %b", k, clk_en[1], exp_en); end
        end
        $display("test_live_drop done");
    endtask

    // ch0 divider=1: clk_en[0] is high after even edges, so odd edges commit.
    task automatic test_halt_priority();
        do_reset(32'd1, 32'd0);
        for (int k = 1; k <= 36; k++) tick();
        vec_count++;
        if (core_en !== 1'b1) begin err_count++; $display("FAIL halt_pre_core_en: got %b want 1", core_en); end
        wb_halt  = 1'b1;
        wb_sleep = 1'b1;
        tick();  // edge 37
        vec_count++;
        if (state !== 2'b10) begin err_count++; $display("FAIL halt_state: got %b want 10", state); end
        vec_count++;
        if (cycle_count !== 32'd37) begin err_count++; $display("FAIL halt_count: got %0d want 37", cycle_count); end
        for (int k = 38; k <= 57; k++) begin
            tick();
            vec_count++;
            if (cycle_count !== 32'd37 || state !== 2'b10 || core_en !== 1'b0)
                begin err_count++; $display("FAIL halt_hold edge %0d: got cnt=%0d st=%b en=%b want 37/10/0", k, cycle_count, state, core_en); end
        end
        wb_halt  = 1'b0;
        wb_sleep = 1'b0;
        resume   = 1'b1;
        tick();  // edge 58: clk_en[0] was low, resume not sampled
        resume   = 1'b0;
        tick();  // edge 59
        vec_count++;
        if (state !== 2'b10) begin err_count++; $display("FAIL halt_short_resume: got %b want 10", state); end
        resume = 1'b1;
        tick();  // edge 60: not an enable edge
        tick();  // edge 61: commits RUN
        resume = 1'b0;
        vec_count++;
        if (state !== 2'b00) begin err_count++; $display("FAIL halt_resume_state: got %b want 00", state); end
        vec_count++;
        if (cycle_count !== 32'd37) begin err_count++; $display("FAIL halt_resume_count: got %0d want 37", cycle_count); end
        tick();  // edge 62
        vec_count++;
        if (cycle_count !== 32'd38) begin err_count++; $display("FAIL halt_count_resumes: got %0d want 38", cycle_count); end
        vec_count++;
        if (core_en !== 1'b1) begin err_count++; $display("FAIL halt_core_en_back: got %b want 1", core_en); end
        $display("test_halt_priority done");
    endtask

    task automatic test_sleep_wake();
        do_reset(32'd1, 32'd0);
        irq_mask = 16'h0004;
        wb_sleep = 1'b1;
        tick(); tick(); tick();  // edge 3 commits SLEEP
        wb_sleep = 1'b0;
        vec_count++;
        if (state !== 2'b01) begin err_count++; $display("FAIL sleep_enter: got %b want 01", state); end
        irq = 16'h0001;
        for (int k = 4; k <= 9; k++) begin
            tick();
            vec_count++;
            if (state !== 2'b01 || wake_pending !== 1'b0)
                begin err_count++; $display("FAIL sleep_masked edge %0d: got st=%b wk=%b want 01/0", k, state, wake_pending); end
        end
        vec_count++;
        if (cycle_count !== 32'd9) begin err_count++; $display("FAIL sleep_count: got %0d want 9", cycle_count); end
        irq = 16'h0004;
        tick();  // edge 10: clk_en[0] low, latch only
        irq = 16'h0000;
        vec_count++;
        if (wake_pending !== 1'b1) begin err_count++; $display("FAIL wake_capture: got %b want 1", wake_pending); end
        vec_count++;
        if (state !== 2'b01) begin err_count++; $display("FAIL wake_no_commit: got %b want 01", state); end
        tick();  // edge 11: commits RUN
        vec_count++;
        if (state !== 2'b00) begin err_count++; $display("FAIL wake_state: got %b want 00", state); end
        vec_count++;
        if (wake_pending !== 1'b0) begin err_count++; $display("FAIL wake_clear: got %b want 0", wake_pending); end
        $display("test_sleep_wake done");
    endtask

    task automatic test_async_reset();
        do_reset(32'd1, 32'd3);
        irq_mask = 16'h0004;
        wb_sleep = 1'b1;
        tick(); tick(); tick();
        wb_sleep = 1'b0;
        irq = 16'h0004;
        tick();  // edge 4: latch without commit
        irq = 16'h0000;
        vec_count++;
        if (wake_pending !== 1'b1 || state !== 2'b01)
            begin err_count++; $display("FAIL areset_setup: got wk=%b st=%b want 1/01", wake_pending, state); end
        #3;
        rst_n = 1'b0;
        #1;
        vec_count++;
        if (clk_en !== 2'b00 || core_en !== 1'b0 || state !== 2'b00 || wake_pending !== 1'b0 || cycle_count !== 32'd0)
            begin err_count++; $display("FAIL areset_immediate: got en=%b core=%b st=%b wk=%b cnt=%0d want all 0", clk_en, core_en, state, wake_pending, cycle_count); end
        tick();
        rst_n = 1'b1;
        tick();
        vec_count++;
        if (state !== 2'b00 || cycle_count !== 32'd1 || wake_pending !== 1'b0)
            begin err_count++; $display("FAIL areset_release: got st=%b cnt=%0d wk=%b want 00/1/0", state, cycle_count, wake_pending); end
        $display("test_async_reset done");
    endtask

    task automatic test_overflow();
        do_reset(32'd0, 32'd0);
        for (int k = 1; k <= 15; k++) tick();
        vec_count++;
        if (w_count !== 4'd15) begin err_count++; $display("FAIL ovf_wrap_15: got %0d want 15", w_count); end
        vec_count++;
        if (s_count !== 4'd15) begin err_count++; $display("FAIL ovf_sat_15: got %0d want 15", s_count); end
        tick();
        vec_count++;
        if (w_count !== 4'd0) begin err_count++; $display("FAIL ovf_wrap_0: got %0d want 0", w_count); end
        vec_count++;
        if (s_count !== 4'd15) begin err_count++; $display("FAIL ovf_sat_hold: got %0d want 15", s_count); end
        tick();
        vec_count++;
        if (w_count !== 4'd1) begin err_count++; $display("FAIL ovf_wrap_1: got %0d want 1", w_count); end
        vec_count++;
        if (s_count !== 4'd15) begin err_count++; $display("FAIL ovf_sat_hold2: got %0d want 15", s_count); end
        $display("test_overflow done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divider();
        test_live_drop();
        test_halt_priority();
        test_sleep_wake();
        test_async_reset();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
